// File: rtl/lfsr_packed_stream_if.sv
// Purpose : control/data bundle between a bit-stream consumer and lfsr_packed_stream.
// Latency : n/a (wires only).
// Backpressure: n/a; the stall indication travels back on 'stalled'.
// Signals: enable/seed_load/seed_value/pop driven by the master;
//          data_out/data_out_valid/full/empty/count/stalled/underflow driven by the slave.
interface lfsr_packed_stream_if #(
    parameter int LFSR_WIDTH = 8,
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    logic                          enable;
    logic                          seed_load;
    logic [LFSR_WIDTH-1:0]         seed_value;
    logic                          pop;
    logic [WORD_WIDTH-1:0]         data_out;
    logic                          data_out_valid;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          stalled;
    logic                          underflow;

    modport master (
        output enable, seed_load, seed_value, pop,
        input  data_out, data_out_valid, full, empty, count, stalled, underflow
    );

    modport slave (
        input  enable, seed_load, seed_value, pop,
        output data_out, data_out_valid, full, empty, count, stalled, underflow
    );
endinterface

// File: rtl/lfsr_packed_stream.sv
// Purpose : Galois LFSR whose output bits are packed LSB-first into words and queued in a FIFO.
// Latency : word poppable the cycle after its last bit; pop -> data_out one cycle later.
// Backpressure: a full FIFO freezes the LFSR on a word's last bit unless a pop frees a slot that cycle.
// Ports   : clk, reset (sync, active-high); bus (slave modport): enable, seed_load, seed_value,
//           pop in; data_out, data_out_valid, full, empty, count, stalled, underflow out.
module lfsr_packed_stream #(
    parameter int                    LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 8'hB8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = LFSR_WIDTH'(1),
    parameter int                    WORD_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    lfsr_packed_stream_if.slave bus
);
    localparam int BW = $clog2(WORD_WIDTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    logic [LFSR_WIDTH-1:0] state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] partial_q, partial_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q;
    logic [WORD_WIDTH-1:0] data_out_q;
    logic                  data_out_valid_q;
    logic                  underflow_q;
    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];

    logic                  out_bit;
    logic [LFSR_WIDTH-1:0] state_adv;
    logic                  last_bit;
    logic                  push_ok;
    logic                  stalled;
    logic                  advance;
    logic                  do_push;
    logic                  do_pop;
    // partial word with the current out_bit merged in; on the last bit this is the finished word
    logic [WORD_WIDTH-1:0] partial_fill;

    always_comb begin
        out_bit      = state_q[0];
        state_adv    = (state_q >> 1) ^ (out_bit ? LFSR_POLY : '0);
        last_bit     = (bit_cnt_q == LAST_BIT);
        // a pop in the same cycle frees the slot the new word needs, even when full
        push_ok      = !full_q || bus.pop;
        stalled      = bus.enable && !bus.seed_load && last_bit && !push_ok;
        advance      = bus.enable && !bus.seed_load && !stalled;
        do_push      = advance && last_bit;
        do_pop       = bus.pop && !empty_q;

        partial_fill = partial_q;
        partial_fill[bit_cnt_q] = out_bit;

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        partial_d = partial_q;
        if (bus.seed_load) begin
            // an all-zero LFSR would lock up, so a zero seed falls back to LFSR_SEED
            state_d   = (bus.seed_value == '0) ? LFSR_SEED : bus.seed_value;
            bit_cnt_d = '0;
            partial_d = '0;
        end else if (advance) begin
            state_d = state_adv;
            if (last_bit) begin
                bit_cnt_d = '0;
                partial_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BW'(1);
                partial_d = partial_fill;
            end
        end

        count_d = count_q + (do_push ? CW'(1) : CW'(0)) - (do_pop ? CW'(1) : CW'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= LFSR_SEED;
            bit_cnt_q        <= '0;
            partial_q        <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            full_q           <= 1'b0;
            empty_q          <= 1'b1;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            underflow_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            bit_cnt_q        <= bit_cnt_d;
            partial_q        <= partial_d;
            count_q          <= count_d;
            full_q           <= (count_d == DEPTH_C);
            empty_q          <= (count_d == '0);
            data_out_valid_q <= do_pop;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q   <= rd_ptr_q + PW'(1);
                data_out_q <= mem[rd_ptr_q];
            end
            if (bus.pop && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    // At full with a simultaneous pop, wr_ptr == rd_ptr and the read takes the old word.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr_q] <= partial_fill;
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;
    assign bus.full           = full_q;
    assign bus.empty          = empty_q;
    assign bus.count          = count_q;
    assign bus.stalled        = stalled;
    assign bus.underflow      = underflow_q;
endmodule

// File: tb/tb_lfsr_packed_stream.sv
module tb_lfsr_packed_stream;
    localparam int LW   = 8;
    localparam int W    = 8;
    localparam int D    = 8;
    localparam int POLY = 'hB8;
    localparam int SEED = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_packed_stream_if #(.LFSR_WIDTH(LW), .WORD_WIDTH(W), .FIFO_DEPTH(D)) bus ();

    lfsr_packed_stream #(
        .LFSR_WIDTH(LW), .LFSR_POLY(8'hB8), .LFSR_SEED(8'h01),
        .WORD_WIDTH(W), .FIFO_DEPTH(D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: bit stream accumulated into words, FIFO as a queue
    int m_state;
    int m_nbits;
    int m_word;
    int q[$];
    int m_dout;
    bit m_dv;
    bit m_under;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit sl, input int sv,
                              input bit pp, input bit stall);
        int b;
        if (rst) begin
            m_state = SEED; m_nbits = 0; m_word = 0;
            q.delete(); m_dout = 0; m_dv = 0; m_under = 0;
            return;
        end
        if (pp && q.size() == 0) m_under = 1;
        m_dv = 0;
        if (pp && q.size() > 0) begin
            m_dout = q.pop_front();
            m_dv = 1;
        end
        if (sl) begin
            m_state = ((sv % 256) == 0) ? SEED : (sv % 256);
            m_nbits = 0; m_word = 0;
        end else if (en && !stall) begin
            b = m_state % 2;
            m_state = (m_state / 2) ^ (b != 0 ? POLY : 0);
            m_word = m_word + (b << m_nbits);
            m_nbits++;
            if (m_nbits == W) begin
                q.push_back(m_word);
                m_nbits = 0; m_word = 0;
            end
        end
    endtask

    // one clock: drive, check combinational stall, clock, check registered outputs vs model
    task automatic step(input bit rst, input bit en, input bit sl, input int sv,
                        input bit pp, output bit st);
        bit exp_stall;
        reset          = rst;
        bus.enable     = en;
        bus.seed_load  = sl;
        bus.seed_value = LW'(sv);
        bus.pop        = pp;
        exp_stall = en && !sl && (m_nbits == W - 1) && !(q.size() < D || pp);
        #1;
        st = bus.stalled;
        if (!rst) chk("stalled", bus.stalled, exp_stall);
        @(posedge clk);
        #1;
        model_edge(rst, en, sl, sv, pp, exp_stall);
        chk("data_out_valid", bus.data_out_valid, m_dv);
        chk("data_out", bus.data_out, m_dout);
        chk("count", bus.count, q.size());
        chk("full", bus.full, q.size() == D);
        chk("empty", bus.empty, q.size() == 0);
        chk("underflow", bus.underflow, m_under);
    endtask

    typedef struct {
        bit rst; bit en; bit sl; int sv; bit pp;
        bit dv; int dout; int cnt; bit emp; bit und;
    } vec_t;

    initial begin
        vec_t tbl[12];
        bit st;

        reset = 1'b1; bus.enable = 0; bus.seed_load = 0; bus.seed_value = '0; bus.pop = 0;

        // basic word: reset, 8 advances -> 8'h71, pop, then pop while empty
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{0, 1, 0, 0, 0, 0, 0, (i == 8) ? 1 : 0, (i == 8) ? 0 : 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 1, 'h71, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 0, 'h71, 0, 1, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 'h71, 0, 1, 1};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].sl, tbl[i].sv, tbl[i].pp, st);
            chk("tbl_dv", bus.data_out_valid, tbl[i].dv);
            chk("tbl_dout", bus.data_out, tbl[i].dout);
            chk("tbl_count", bus.count, tbl[i].cnt);
            chk("tbl_empty", bus.empty, tbl[i].emp);
            chk("tbl_underflow", bus.underflow, tbl[i].und);
        end

        // seed mid-word with zero seed: partial bits dropped, next word restarts at 8'h71
        step(1, 0, 0, 0, 0, st);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, st);
        step(0, 1, 1, 0, 0, st);
        chk("seed_count", bus.count, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, st);
        step(0, 0, 0, 0, 1, st);
        chk("seed_word", bus.data_out, 'h71);
        chk("seed_word_vld", bus.data_out_valid, 1);

        // fill and stall
        step(1, 0, 0, 0, 0, st);
        for (int i = 0; i < 64; i++) step(0, 1, 0, 0, 0, st);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 8);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, st);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 0, st);
            chk("fill_stalled", st, 1);
        end
        step(0, 1, 0, 0, 1, st);
        chk("full_pop_stalled", st, 0);
        chk("full_pop_dout", bus.data_out, 'h71);
        chk("full_pop_count", bus.count, 8);
        chk("full_pop_full", bus.full, 1);
        // drain: the word completed after the stall must match the model (state was frozen)
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, st);
        chk("drain_empty", bus.empty, 1);
        chk("drain_underflow", bus.underflow, 1);

        // reset mid-operation with pop and enable asserted
        step(1, 0, 0, 0, 0, st);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0, st);
        chk("five_words", bus.count, 5);
        step(1, 1, 0, 0, 1, st);
        chk("rst_dv", bus.data_out_valid, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_underflow", bus.underflow, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, st);
        step(0, 0, 0, 0, 1, st);
        chk("rst_restart_word", bus.data_out, 'h71);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_en, r_sl, r_pp;
            int r_sv;
            r_rst = ($urandom_range(0, 399) == 0);
            r_en  = ($urandom_range(0, 9) < 8);
            r_sl  = ($urandom_range(0, 39) == 0);
            r_sv  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
            r_pp  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 15 : 60));
            step(r_rst, r_en, r_sl, r_sv, r_pp, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
